// File: rtl/odometer_meas_sequencer_if.sv
// Bundles the sequencer's control/config inputs, odometer handshake and result outputs.
// master: the sequencer (drives select/load/trigger/result/status); slave: the
//   surrounding control logic, odometer and result consumer (drives config, MEAS_STRESS, BF_COUNT, RES_ACK).
interface odometer_meas_sequencer_if #(
  parameter int STRESS_W = 16
);
  // control / config
  logic                en;
  logic [2:0]          inv_mask;
  logic                ac_dc_cfg;
  logic [STRESS_W-1:0] stress_cyc;
  logic [7:0]          num_meas;
  // odometer side
  logic                meas_stress;
  logic [11:0]         bf_count;
  logic                sel_inv97;
  logic                sel_inv99;
  logic                sel_inv101;
  logic                start;
  logic                ac_dc;
  logic                load;
  logic                meas_trig;
  // result / status
  logic                res_ack;
  logic [11:0]         res_data;
  logic [1:0]          res_tag;
  logic                res_valid;
  logic                busy;
  logic                timeout_err;
  logic [7:0]          meas_cnt;

  modport master (
    input  en, inv_mask, ac_dc_cfg, stress_cyc, num_meas, meas_stress, bf_count, res_ack,
    output sel_inv97, sel_inv99, sel_inv101, start, ac_dc, load, meas_trig,
           res_data, res_tag, res_valid, busy, timeout_err, meas_cnt
  );

  modport slave (
    output en, inv_mask, ac_dc_cfg, stress_cyc, num_meas, meas_stress, bf_count, res_ack,
    input  sel_inv97, sel_inv99, sel_inv101, start, ac_dc, load, meas_trig,
           res_data, res_tag, res_valid, busy, timeout_err, meas_cnt
  );
endinterface

// File: rtl/odometer_meas_sequencer.sv
// Stress/measure scheduler for one stacked odometer shared by the INV97/99/101 ROSC variants.
// Ports: clk, rst_n (async active-low), bus (master side of odometer_meas_sequencer_if):
//   config in (en, inv_mask, ac_dc_cfg, stress_cyc, num_meas), odometer I/O, tagged result out.
module odometer_meas_sequencer #(
  parameter int STRESS_W  = 16,
  parameter int TMO_W     = 20,
  parameter int LOAD_CYC  = 2,
  parameter int SETUP_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  odometer_meas_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_STRESS, S_SETUP, S_LOADP, S_SETTLE, S_TRIG, S_WAITD, S_CAPT
  } state_t;

  localparam logic [7:0]       LOAD_LAST   = 8'(LOAD_CYC - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETUP_CYC - 1);
  // Expiry is flagged on the edge that would take the counter to all-ones,
  // so the error appears exactly 2**TMO_W-1 cycles after TRIG entry.
  localparam logic [TMO_W-1:0] TMO_LAST    = {TMO_W{1'b1}} - TMO_W'(1);

  state_t state, state_nxt;

  logic                ms_meta, ms_s;
  logic                en_q, en_rise;
  logic [2:0]          mask_l;
  logic                acdc_l;
  logic [7:0]          num_l;
  logic [STRESS_W-1:0] stress_l, stress_cnt, stress_last;
  logic [7:0]          phase_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [1:0]          ptr;
  logic [2:0]          sel;
  logic                ac_dc_r;
  logic [11:0]         res_data_r;
  logic [1:0]          res_tag_r;
  logic                res_valid_r;
  logic                timeout_err_r;
  logic [7:0]          meas_cnt_r;
  logic [8:0]          cnt_done;
  logic                last_meas;
  logic                tmo_hit;
  logic                ld_cfg, start_run, capture, tmo_fire;

  function automatic logic [1:0] lowest_set(input logic [2:0] m);
    if (m[0]) return 2'd0;
    else if (m[1]) return 2'd1;
    else return 2'd2;
  endfunction

  // Next enabled variant after p, wrapping 101->97; a single enabled bit repeats.
  function automatic logic [1:0] next_set(input logic [1:0] p, input logic [2:0] m);
    logic [1:0] c1, c2;
    c1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (m[c1]) return c1;
    else if (m[c2]) return c2;
    else return p;
  endfunction

  assign en_rise     = bus.en & ~en_q;
  assign stress_last = stress_l - STRESS_W'(1);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign cnt_done    = {1'b0, meas_cnt_r} + 9'd1;
  assign last_meas   = (num_l != 8'd0) && (cnt_done == {1'b0, num_l});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_cfg    = 1'b0;
    start_run = 1'b0;
    capture   = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (en_rise) begin
          ld_cfg = 1'b1;
          // Decision uses the live inputs: the latched copies update on this same edge.
          if (bus.inv_mask != 3'd0) begin
            start_run = 1'b1;
            state_nxt = (bus.stress_cyc == '0) ? S_SETUP : S_STRESS;
          end
        end
      end
      S_STRESS: begin
        if (!bus.en)                        state_nxt = S_IDLE;
        else if (stress_cnt == stress_last) state_nxt = S_SETUP;
      end
      S_SETUP:  state_nxt = S_LOADP;
      S_LOADP:  if (phase_cnt == LOAD_LAST)   state_nxt = S_SETTLE;
      S_SETTLE: if (phase_cnt == SETTLE_LAST) state_nxt = S_TRIG;
      S_TRIG: begin
        if (ms_s) state_nxt = S_WAITD;
        else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WAITD: begin
        if (!ms_s) state_nxt = S_CAPT;
        else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CAPT: begin
        // Never overwrite a result the consumer has not taken yet.
        if (!res_valid_r || bus.res_ack) begin
          capture = 1'b1;
          if (last_meas || !bus.en)  state_nxt = S_IDLE;
          else if (stress_l == '0)   state_nxt = S_SETUP;
          else                       state_nxt = S_STRESS;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_meta       <= 1'b0;
      ms_s          <= 1'b0;
      en_q          <= 1'b0;
      mask_l        <= 3'd0;
      acdc_l        <= 1'b0;
      num_l         <= 8'd0;
      stress_l      <= '0;
      stress_cnt    <= '0;
      phase_cnt     <= 8'd0;
      tmo_cnt       <= '0;
      ptr           <= 2'd0;
      sel           <= 3'd0;
      ac_dc_r       <= 1'b0;
      res_data_r    <= 12'd0;
      res_tag_r     <= 2'd0;
      res_valid_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      meas_cnt_r    <= 8'd0;
    end else begin
      // MEAS_STRESS is asynchronous to clk.
      ms_meta <= bus.meas_stress;
      ms_s    <= ms_meta;
      en_q    <= bus.en;

      if (ld_cfg) begin
        mask_l        <= bus.inv_mask;
        acdc_l        <= bus.ac_dc_cfg;
        num_l         <= bus.num_meas;
        stress_l      <= bus.stress_cyc;
        timeout_err_r <= 1'b0;
        meas_cnt_r    <= 8'd0;
      end
      if (start_run) ptr <= lowest_set(bus.inv_mask);

      if (state == S_STRESS) stress_cnt <= stress_cnt + STRESS_W'(1);
      else                   stress_cnt <= '0;

      if ((state == S_LOADP || state == S_SETTLE) && state_nxt == state)
        phase_cnt <= phase_cnt + 8'd1;
      else
        phase_cnt <= 8'd0;

      // Zero in every other state, so it starts from 0 on TRIG entry.
      if (state == S_TRIG || state == S_WAITD) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                     tmo_cnt <= '0;

      // Select lines and AC_DC change only here and hold until the next SETUP.
      if (state == S_SETUP) begin
        sel     <= {ptr == 2'd2, ptr == 2'd1, ptr == 2'd0};
        ac_dc_r <= acdc_l;
      end

      if (tmo_fire) timeout_err_r <= 1'b1;

      if (capture) begin
        res_data_r  <= bus.bf_count;
        res_tag_r   <= ptr;
        res_valid_r <= 1'b1;
        if (meas_cnt_r != 8'hFF) meas_cnt_r <= meas_cnt_r + 8'd1;
        ptr <= next_set(ptr, mask_l);
      end else if (bus.res_ack) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  // Strobes decode the state register directly so reset removes them at once.
  assign bus.load        = (state == S_LOADP);
  assign bus.meas_trig   = (state == S_TRIG);
  assign bus.busy        = (state != S_IDLE);
  assign bus.start       = (state != S_IDLE);
  assign bus.sel_inv97   = sel[0];
  assign bus.sel_inv99   = sel[1];
  assign bus.sel_inv101  = sel[2];
  assign bus.ac_dc       = ac_dc_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_tag     = res_tag_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.meas_cnt    = meas_cnt_r;

endmodule

// File: tb/tb_odometer_meas_sequencer.sv
module tb_odometer_meas_sequencer;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  odometer_meas_sequencer_if #(.STRESS_W(16)) bus ();

  odometer_meas_sequencer #(
    .STRESS_W (16),
    .TMO_W    (8),
    .LOAD_CYC (2),
    .SETUP_CYC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] outs;
  assign outs = {bus.sel_inv97, bus.sel_inv99, bus.sel_inv101, bus.start, bus.ac_dc,
                 bus.load, bus.meas_trig, bus.res_data, bus.res_tag, bus.res_valid,
                 bus.busy, bus.timeout_err, bus.meas_cnt};

  logic [13:0] sb[$];       // expected {tag, data}
  logic [11:0] odo_vals[$]; // counts the odometer model will report, in order
  logic        odo_on = 1'b1;
  logic        ack_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic expect_res(input logic [1:0] tag, input logic [11:0] val);
    sb.push_back({tag, val});
    odo_vals.push_back(val);
  endtask

  // Consumer: acks one cycle after a result appears.
  initial begin
    bus.res_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.res_ack = ack_en ? bus.res_valid : 1'b0;
    end
  end

  // Odometer model: on MEAS_TRIG rise, raise MEAS_STRESS after 3 cycles for 5 cycles,
  // presenting the next queued count as it falls.
  initial begin : odo_model
    logic        mt_prev;
    logic [11:0] v;
    mt_prev         = 1'b0;
    bus.meas_stress = 1'b0;
    bus.bf_count    = 12'd0;
    forever begin
      @(posedge clk);
      #1;
      if (odo_on && bus.meas_trig && !mt_prev) begin
        v = (odo_vals.size() != 0) ? odo_vals.pop_front() : 12'hFFF;
        repeat (3) @(posedge clk);
        #1 bus.meas_stress = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.bf_count    = v;
        bus.meas_stress = 1'b0;
      end
      mt_prev = bus.meas_trig;
    end
  end

  // Scoreboard monitor: compares each newly presented result against the queue head.
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !bus.res_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 32'({bus.res_tag, bus.res_data}), 32'h0);
        end else begin
          logic [13:0] e;
          e = sb.pop_front();
          check("sb_res_data", 32'(bus.res_data), 32'(e[11:0]));
          check("sb_res_tag", 32'(bus.res_tag), 32'(e[13:12]));
        end
        seen = 1'b1;
      end
      if (bus.res_ack) seen = 1'b0;
    end
  end

  // Pulse bookkeeping for LOAD width and MEAS_TRIG activity.
  int   lw = 0;
  int   load_pulses = 0;
  int   load_bad = 0;
  int   mt_pulses = 0;
  logic mt_q = 1'b0;
  always @(negedge clk) begin
    if (bus.load) lw++;
    else if (lw != 0) begin
      load_pulses++;
      if (lw != 2) load_bad++;
      lw = 0;
    end
    if (bus.meas_trig && !mt_q) mt_pulses++;
    mt_q = bus.meas_trig;
  end

  task automatic wait_busy_low(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.busy), 32'h0);
  endtask

  task automatic wait_trig(input logic lvl, input int budget, input string name);
    int n = 0;
    while (bus.meas_trig !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.meas_trig), 32'(lvl));
  endtask

  task automatic run_cfg(input logic [2:0] mask, input logic [15:0] stress,
                         input logic [7:0] num, input logic acdc);
    bus.inv_mask   = mask;
    bus.stress_cyc = stress;
    bus.num_meas   = num;
    bus.ac_dc_cfg  = acdc;
    bus.en         = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int lp0, mt0, t0, n;
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.inv_mask   = 3'd0;
    bus.ac_dc_cfg  = 1'b0;
    bus.stress_cyc = 16'd0;
    bus.num_meas   = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: round-robin over INV97/INV101, four measurements
    lp0 = load_pulses;
    expect_res(2'd0, 12'h123);
    expect_res(2'd2, 12'h456);
    expect_res(2'd0, 12'h789);
    expect_res(2'd2, 12'hABC);
    run_cfg(3'b101, 16'd10, 8'd4, 1'b1);
    wait_busy_low(1000, "t1_busy_falls");
    repeat (3) @(negedge clk);
    check("t1_meas_cnt", 32'(bus.meas_cnt), 32'd4);
    check("t1_load_pulses", 32'(load_pulses - lp0), 32'd4);
    check("t1_load_width_bad", 32'(load_bad), 32'd0);
    check("t1_ac_dc", 32'(bus.ac_dc), 32'd1);
    check("t1_sel_held", 32'({bus.sel_inv101, bus.sel_inv99, bus.sel_inv97}), 32'b100);
    check("t1_sb_drained", 32'(sb.size()), 32'd0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);

    // 2: odometer never answers -> timeout after 255 cycles
    odo_on = 1'b0;
    run_cfg(3'b001, 16'd0, 8'd1, 1'b0);
    wait_trig(1'b1, 50, "t2_trig_rise");
    t0 = cyc;
    n  = 0;
    while (!bus.timeout_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t2_timeout_err", 32'(bus.timeout_err), 32'd1);
    check("t2_timeout_latency", 32'(cyc - t0), 32'd255);
    check("t2_meas_trig_low", 32'(bus.meas_trig), 32'd0);
    check("t2_idle", 32'(bus.busy), 32'd0);
    check("t2_meas_cnt", 32'(bus.meas_cnt), 32'd0);
    bus.en = 1'b0;
    odo_on = 1'b1;
    repeat (2) @(negedge clk);

    // 3: consumer withholds ack -> second result stalls in CAPT
    ack_en = 1'b0;
    mt0 = mt_pulses;
    expect_res(2'd0, 12'h0F1);
    expect_res(2'd1, 12'h2E3);
    run_cfg(3'b011, 16'd3, 8'd2, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_timeout_cleared", 32'(bus.timeout_err), 32'd0);
    n = 0;
    while (mt_pulses < mt0 + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t3_second_trig", 32'(mt_pulses - mt0), 32'd2);
    repeat (20) @(negedge clk);
    check("t3_held_valid", 32'(bus.res_valid), 32'd1);
    check("t3_held_data", 32'(bus.res_data), 32'h0F1);
    check("t3_held_tag", 32'(bus.res_tag), 32'd0);
    check("t3_stalled_busy", 32'(bus.busy), 32'd1);
    check("t3_stalled_cnt", 32'(bus.meas_cnt), 32'd1);
    ack_en = 1'b1;
    wait_busy_low(100, "t3_busy_falls");
    repeat (3) @(negedge clk);
    check("t3_meas_cnt", 32'(bus.meas_cnt), 32'd2);
    check("t3_sb_drained", 32'(sb.size()), 32'd0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);

    // 4a: EN dropped during STRESS -> IDLE next cycle, no LOAD
    lp0 = load_pulses;
    run_cfg(3'b001, 16'd50, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("t4a_in_stress", 32'(bus.busy), 32'd1);
    bus.en = 1'b0;
    @(negedge clk);
    check("t4a_abort_idle", 32'(bus.busy), 32'd0);
    check("t4a_no_load", 32'(load_pulses - lp0), 32'd0);
    repeat (2) @(negedge clk);

    // 4b: EN dropped during WAITD -> capture completes, then IDLE
    mt0 = mt_pulses;
    expect_res(2'd2, 12'h5A5);
    run_cfg(3'b100, 16'd0, 8'd0, 1'b0);
    wait_trig(1'b1, 50, "t4b_trig_rise");
    wait_trig(1'b0, 50, "t4b_trig_fall");
    bus.en = 1'b0;
    wait_busy_low(100, "t4b_busy_falls");
    repeat (3) @(negedge clk);
    check("t4b_meas_cnt", 32'(bus.meas_cnt), 32'd1);
    check("t4b_one_trig", 32'(mt_pulses - mt0), 32'd1);
    check("t4b_sb_drained", 32'(sb.size()), 32'd0);

    // 5: empty mask -> stays IDLE
    lp0 = load_pulses;
    mt0 = mt_pulses;
    run_cfg(3'b000, 16'd2, 8'd1, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_start", 32'(bus.start), 32'd0);
    check("t5_cnt_cleared", 32'(bus.meas_cnt), 32'd0);
    check("t5_no_load", 32'(load_pulses - lp0), 32'd0);
    check("t5_no_trig", 32'(mt_pulses - mt0), 32'd0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);

    // 6: reset during TRIG, then restart from INV97
    expect_res(2'd0, 12'h111);
    expect_res(2'd1, 12'h222);
    run_cfg(3'b111, 16'd0, 8'd0, 1'b0);
    n = 0;
    while (bus.meas_cnt != 8'd2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_done", 32'(bus.meas_cnt), 32'd2);
    odo_on = 1'b0;
    wait_trig(1'b1, 100, "t6_third_trig");
    #2;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    check("t6_async_reset_outs", outs, 32'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    odo_on = 1'b1;
    @(negedge clk);
    expect_res(2'd0, 12'h333);
    run_cfg(3'b111, 16'd2, 8'd1, 1'b0);
    wait_busy_low(200, "t6_busy_falls");
    repeat (3) @(negedge clk);
    check("t6_meas_cnt", 32'(bus.meas_cnt), 32'd1);
    check("t6_sb_drained", 32'(sb.size()), 32'd0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
